// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants used by the fetch queue and its FIFO.
`default_nettype none

package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pcplus4;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: IF-stage control, instruction memory port and IF/ID head outputs.
`default_nettype none

interface fetch_queue_if
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               stall;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rd;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  pcplus4_out;
  logic               valid_out;
  logic [CW-1:0]      count;

  // Queue side
  modport master (
    input  stall, redirect, redirect_pc, imem_rd,
    output imem_addr, instr_out, pcplus4_out, valid_out, count
  );

  // Pipeline / memory side
  modport slave (
    output stall, redirect, redirect_pc, imem_rd,
    input  imem_addr, instr_out, pcplus4_out, valid_out, count
  );

endinterface

`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: circular entry storage with read/write pointers and occupancy count.
`default_nettype none

module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk_i,
  input  wire logic                     rst_i,
  input  wire logic                     flush_i,
  input  wire logic                     push_i,
  input  wire logic                     pop_i,
  input  wire fq_entry_t                wdata_i,
  output fq_entry_t                     head_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       count_q,  count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointer overflow is the modulo wrap
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_d = count_q + 1'b1;
      else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// fetch_queue: IF-stage prefetch queue with redirect flush.
// Optional macro FETCH_QUEUE_BYPASS_EN presents imem data directly when the queue is empty.
`default_nettype none

module fetch_queue
  import mips_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  fetch_queue_if.master   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [CW-1:0]     count;
  logic              stored_valid;
  logic              full;
  logic              push;
  logic              pop;
  logic              bypass_take;
  fq_entry_t         head;
  fq_entry_t         wdata;

  assign pc_plus4     = fetch_pc_q + 32'd4;
  assign stored_valid = (count != '0);
  assign full         = (count == CW'(DEPTH));
  assign pop          = stored_valid && !bus.stall && !bus.redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue: the bypassed instruction is consumed straight from memory
  assign bypass_take = !stored_valid && !bus.redirect && !bus.stall;
`else
  assign bypass_take = 1'b0;
`endif

  assign push  = !bus.redirect && (!full || pop) && !bypass_take;
  assign wdata = '{pcplus4: pc_plus4, instr: bus.imem_rd};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect)              fetch_pc_d = bus.redirect_pc;
    else if (push || bypass_take)  fetch_pc_d = pc_plus4;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) fetch_pc_q <= RESET_PC;
    else       fetch_pc_q <= fetch_pc_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (bus.redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    bus.valid_out   = stored_valid;
    bus.instr_out   = stored_valid ? head.instr   : NOP_INSTR;
    bus.pcplus4_out = stored_valid ? head.pcplus4 : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (!stored_valid && !bus.redirect) begin
      bus.valid_out   = 1'b1;
      bus.instr_out   = bus.imem_rd;
      bus.pcplus4_out = pc_plus4;
    end
`endif
  end

  assign bus.imem_addr = fetch_pc_q;
  assign bus.count     = count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, queue-model scoreboard, reset corners.
`default_nettype none

module tb_fetch_queue;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // imem[i] = i, word addressed
  assign bus.imem_rd = {2'b00, bus.imem_addr[31:2]};

  fq_entry_t   mq [$];
  logic [31:0] m_pc;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    int          cnt;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks outputs against the model, then advances the model
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    int        sz;
    logic      pop;
    logic      push;
    fq_entry_t e;
    @(negedge clk);
    bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc;
    #1;
    sz = mq.size();
    chk("count", 32'(bus.count), 32'(sz));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("valid_out", 32'(bus.valid_out), 32'(sz != 0));
    if (sz == 0) begin
      chk("empty_instr", bus.instr_out, 32'h0);
      chk("empty_pc4", bus.pcplus4_out, 32'h0);
    end
    pop  = !rd && !st && (sz != 0);
    push = !rd && ((sz < DEPTH) || pop);
    if (pop) begin
      e = mq.pop_front();
      chk("sb_instr", bus.instr_out, e.instr);
      chk("sb_pc4", bus.pcplus4_out, e.pcplus4);
    end
    if (rd) begin
      mq.delete();
      m_pc = rpc;
    end else if (push) begin
      mq.push_back('{pcplus4: m_pc + 32'd4, instr: {2'b00, m_pc[31:2]}});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_instr", bus.instr_out, 32'h0);
    chk("rst_pc4", bus.pcplus4_out, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
  endtask

  initial begin
    //         st    rd    rpc            cnt addr          instr         pc4
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        0, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1, 32'h4,        32'h0,        32'h4};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1, 32'h8,        32'h1,        32'h8};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1, 32'hC,        32'h2,        32'hC};
    vecs[4]  = '{1'b0, 1'b1, 32'h0,        1, 32'h10,       32'h3,        32'h10};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        0, 32'h0,        32'h0,        32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        1, 32'h4,        32'h0,        32'h4};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        2, 32'h8,        32'h0,        32'h4};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        3, 32'hC,        32'h0,        32'h4};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,        4, 32'h10,       32'h0,        32'h4};
    vecs[10] = '{1'b1, 1'b0, 32'h0,        4, 32'h10,       32'h0,        32'h4};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        4, 32'h10,       32'h0,        32'h4};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        4, 32'h14,       32'h1,        32'h8};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        4, 32'h18,       32'h2,        32'hC};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        4, 32'h1C,       32'h3,        32'h10};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        4, 32'h20,       32'h4,        32'h14};
    vecs[16] = '{1'b1, 1'b1, 32'h100,      4, 32'h24,       32'h5,        32'h18};
    vecs[17] = '{1'b1, 1'b0, 32'h0,        0, 32'h100,      32'h0,        32'h0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,        1, 32'h104,      32'h40,       32'h104};
    vecs[19] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1, 32'h108,     32'h41,       32'h108};
    vecs[20] = '{1'b1, 1'b0, 32'h0,        0, 32'hFFFF_FFFC, 32'h0,       32'h0};
    vecs[21] = '{1'b1, 1'b0, 32'h0,        1, 32'h0,        32'h3FFF_FFFF, 32'h0};
    vecs[22] = '{1'b0, 1'b0, 32'h0,        2, 32'h4,        32'h3FFF_FFFF, 32'h0};

    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;
    mq.delete();
    m_pc = 32'h0;

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].st, vecs[i].rd, vecs[i].rpc);
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(bus.valid_out), 32'(vecs[i].cnt != 0));
      chk($sformatf("v%0d_instr", i), bus.instr_out, vecs[i].instr);
      chk($sformatf("v%0d_pc4", i), bus.pcplus4_out, vecs[i].pc4);
    end

    // Mixed traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, rpc);
    end

    // Reset mid-fill overrides redirect and stall
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1; bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0; bus.redirect = 1'b0;
    mq.delete();
    m_pc = 32'h0;
    // First cycle after release fetches RESET_PC and pushes
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("post_rst_count", 32'(bus.count), 32'h1);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
